// File: rtl/reaction_timing_ctrl.sv
// Reaction-timer datapath: PREP random delay, TEST reaction counter, result latch.
// Optional best-score tracking is built when BEST_SCORE_EN is defined.
module reaction_timing_ctrl #(
    parameter int PREP_MIN_MS   = 1000,
    parameter int PREP_MASK     = 2047,
    parameter int TEST_LIMIT_MS = 1000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rising_edge_1khz,
    input  logic [2:0]  current_state,
    output logic        prep_timeout,
    output logic        test_timeout,
    output logic [13:0] reaction_ms,
    output logic        result_valid,
    output logic        result_ok,
    output logic [13:0] best_ms,
    output logic        new_best
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_TEST = 3'd2,
        ST_OK   = 3'd3,
        ST_FAIL = 3'd4
    } state_e;

    localparam logic [13:0] PREP_MIN_W   = 14'(PREP_MIN_MS);
    localparam logic [13:0] PREP_MASK_W  = 14'(PREP_MASK);
    localparam logic [13:0] TEST_LIMIT_W = 14'(TEST_LIMIT_MS);
    localparam logic [13:0] CNT_MAX      = 14'h3FFF;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    state_e      cur_state;
    logic        entry;

    state_e      prev_state_q, prev_state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [13:0] prep_target_q, prep_target_d;
    logic [13:0] prep_cnt_q, prep_cnt_d;
    logic [13:0] rt_cnt_q, rt_cnt_d;
    logic        prep_to_q, prep_to_d;
    logic        test_to_q, test_to_d;
    logic [13:0] reaction_q, reaction_d;
    logic        result_ok_q, result_ok_d;
    // result_valid is a one-cycle strobe with no ready: the consumer must take it that cycle.
    logic        result_valid_q, result_valid_d;
`ifdef BEST_SCORE_EN
    logic [13:0] best_q, best_d;
    logic        new_best_q, new_best_d;
`endif

    // Unused encodings collapse onto IDLE before any entry detection.
    always_comb begin
        cur_state = ST_IDLE;
        if (current_state <= 3'd4) begin
            cur_state = state_e'(current_state);
        end
    end

    assign entry = (cur_state != prev_state_q);

    always_comb begin
        prev_state_d   = cur_state;
        lfsr_d         = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        prep_target_d  = prep_target_q;
        prep_cnt_d     = prep_cnt_q;
        rt_cnt_d       = rt_cnt_q;
        prep_to_d      = 1'b0;
        test_to_d      = 1'b0;
        reaction_d     = reaction_q;
        result_ok_d    = result_ok_q;
        result_valid_d = 1'b0;
`ifdef BEST_SCORE_EN
        best_d         = best_q;
        new_best_d     = 1'b0;
`endif

        if (cur_state == ST_PREP) begin
            if (entry) begin
                prep_target_d = PREP_MIN_W + (lfsr_q[13:0] & PREP_MASK_W);
                prep_cnt_d    = 14'd0;
            end else begin
                if (rising_edge_1khz && (prep_cnt_q != CNT_MAX)) begin
                    prep_cnt_d = prep_cnt_q + 14'd1;
                end
                prep_to_d = (prep_cnt_q >= prep_target_q);
            end
        end

        if (cur_state == ST_TEST) begin
            if (entry) begin
                rt_cnt_d = 14'd0;
            end else begin
                if (rising_edge_1khz && (rt_cnt_q != CNT_MAX)) begin
                    rt_cnt_d = rt_cnt_q + 14'd1;
                end
                test_to_d = (rt_cnt_q >= TEST_LIMIT_W);
            end
        end

        // Only transitions out of PREP/TEST into a RESULT state latch a result.
        if (entry && (prev_state_q == ST_TEST) && (cur_state == ST_OK)) begin
            reaction_d     = rt_cnt_q;
            result_ok_d    = 1'b1;
            result_valid_d = 1'b1;
`ifdef BEST_SCORE_EN
            if (rt_cnt_q < best_q) begin
                best_d     = rt_cnt_q;
                new_best_d = 1'b1;
            end
`endif
        end else if (entry && (cur_state == ST_FAIL) &&
                     ((prev_state_q == ST_TEST) || (prev_state_q == ST_PREP))) begin
            reaction_d     = CNT_MAX;
            result_ok_d    = 1'b0;
            result_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_state_q   <= ST_IDLE;
            lfsr_q         <= LFSR_SEED;
            prep_target_q  <= PREP_MIN_W;
            prep_cnt_q     <= 14'd0;
            rt_cnt_q       <= 14'd0;
            prep_to_q      <= 1'b0;
            test_to_q      <= 1'b0;
            reaction_q     <= 14'd0;
            result_ok_q    <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef BEST_SCORE_EN
            best_q         <= CNT_MAX;
            new_best_q     <= 1'b0;
`endif
        end else begin
            prev_state_q   <= prev_state_d;
            lfsr_q         <= lfsr_d;
            prep_target_q  <= prep_target_d;
            prep_cnt_q     <= prep_cnt_d;
            rt_cnt_q       <= rt_cnt_d;
            prep_to_q      <= prep_to_d;
            test_to_q      <= test_to_d;
            reaction_q     <= reaction_d;
            result_ok_q    <= result_ok_d;
            result_valid_q <= result_valid_d;
`ifdef BEST_SCORE_EN
            best_q         <= best_d;
            new_best_q     <= new_best_d;
`endif
        end
    end

    // Timeouts are masked by the live state so they drop in the very cycle the state leaves.
    assign prep_timeout = prep_to_q & (cur_state == ST_PREP);
    assign test_timeout = test_to_q & (cur_state == ST_TEST);
    assign reaction_ms  = reaction_q;
    assign result_ok    = result_ok_q;
    assign result_valid = result_valid_q;
`ifdef BEST_SCORE_EN
    assign best_ms      = best_q;
    assign new_best     = new_best_q;
`else
    assign best_ms      = CNT_MAX;
    assign new_best     = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timing_ctrl.sv
// Directed bench for reaction_timing_ctrl; results are checked through an expected queue.
// Honours BEST_SCORE_EN the same way the design does.
module tb_reaction_timing_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_TEST = 3'd2;
    localparam logic [2:0] S_OK   = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    logic        clock;
    logic        reset_n;
    logic        rising_edge_1khz;
    logic [2:0]  current_state;
    logic        prep_timeout;
    logic        test_timeout;
    logic [13:0] reaction_ms;
    logic        result_valid;
    logic        result_ok;
    logic [13:0] best_ms;
    logic        new_best;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [29:0] exp_q[$];
    logic [13:0] exp_best = 14'h3FFF;
    logic [15:0] m_lfsr;

    reaction_timing_ctrl dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .rising_edge_1khz (rising_edge_1khz),
        .current_state    (current_state),
        .prep_timeout     (prep_timeout),
        .test_timeout     (test_timeout),
        .reaction_ms      (reaction_ms),
        .result_valid     (result_valid),
        .result_ok        (result_ok),
        .best_ms          (best_ms),
        .new_best         (new_best)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference LFSR: Fibonacci taps 16,14,13,11, seeded on reset
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        rising_edge_1khz = 1'b1;
        repeat (n) cyc();
        rising_edge_1khz = 1'b0;
    endtask

    task automatic push_ok(input logic [13:0] rt);
        logic nb;
        nb = 1'b0;
`ifdef BEST_SCORE_EN
        nb = (rt < exp_best);
        if (nb) exp_best = rt;
`endif
        exp_q.push_back({rt, 1'b1, nb, exp_best});
    endtask

    task automatic push_fail();
        exp_q.push_back({14'h3FFF, 1'b0, 1'b0, exp_best});
    endtask

    task automatic run_ok(input int n);
        current_state = S_PREP;
        cyc();
        current_state = S_TEST;
        cyc();
        tick_n(n);
        push_ok(14'(n));
        current_state = S_OK;
        cyc();
        current_state = S_IDLE;
        cyc();
        check("valid_one_cycle", 32'(result_valid), 32'd0);
        check("reaction_hold", 32'(reaction_ms), 32'(n));
        check("ok_hold", 32'(result_ok), 32'd1);
    endtask

    task automatic prep_timing(input string tag);
        int n;
        n = int'(m_lfsr & 16'h07FF);
        current_state = S_PREP;
        cyc();
        check({tag, "_entry"}, 32'(prep_timeout), 32'd0);
        tick_n(1000 + n - 1);
        check({tag, "_before"}, 32'(prep_timeout), 32'd0);
        tick_n(1);
        check({tag, "_reach"}, 32'(prep_timeout), 32'd0);
        cyc();
        check({tag, "_rise"}, 32'(prep_timeout), 32'd1);
        repeat (3) cyc();
        check({tag, "_hold"}, 32'(prep_timeout), 32'd1);
        current_state = S_TEST;
        #1;
        check({tag, "_exit_gate"}, 32'(prep_timeout), 32'd0);
        cyc();
        current_state = S_IDLE;
        cyc();
    endtask

    // scoreboard: pop one expected result per result_valid cycle
    always @(negedge clock) begin
        logic [29:0] e;
        if (reset_n) begin
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_reaction_ms", 32'(reaction_ms), 32'(e[29:16]));
                    check("sb_result_ok", 32'(result_ok), 32'(e[15]));
                    check("sb_new_best", 32'(new_best), 32'(e[14]));
                    check("sb_best_ms", 32'(best_ms), 32'(e[13:0]));
                end
            end else begin
                check("new_best_without_valid", 32'(new_best), 32'd0);
            end
        end
    end

    initial begin
        reset_n          = 1'b0;
        rising_edge_1khz = 1'b0;
        current_state    = S_IDLE;
        repeat (3) cyc();
        check("rst_prep_timeout", 32'(prep_timeout), 32'd0);
        check("rst_test_timeout", 32'(test_timeout), 32'd0);
        check("rst_reaction_ms", 32'(reaction_ms), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result_ok", 32'(result_ok), 32'd0);
        check("rst_best_ms", 32'(best_ms), 32'h3FFF);
        check("rst_new_best", 32'(new_best), 32'd0);
        reset_n = 1'b1;
        repeat ($urandom_range(1, 20)) cyc();

        // random PREP delay timing, then exit gating
        prep_timing("prep");

        // first OK run of 250
        run_ok(250);

        // TEST runs to its limit, then fails
        current_state = S_PREP;
        cyc();
        current_state = S_TEST;
        cyc();
        check("tto_entry", 32'(test_timeout), 32'd0);
        tick_n(999);
        check("tto_before", 32'(test_timeout), 32'd0);
        tick_n(1);
        check("tto_reach", 32'(test_timeout), 32'd0);
        cyc();
        check("tto_rise", 32'(test_timeout), 32'd1);
        check("tto_prep_low", 32'(prep_timeout), 32'd0);
        push_fail();
        current_state = S_FAIL;
        #1;
        check("tto_exit_gate", 32'(test_timeout), 32'd0);
        cyc();
        current_state = S_IDLE;
        repeat (4) cyc();
        check("fail_hold_reaction", 32'(reaction_ms), 32'h3FFF);
        check("fail_hold_ok", 32'(result_ok), 32'd0);

        // aborted PREP and TEST latch nothing
        current_state = S_PREP;
        cyc();
        tick_n(3);
        current_state = S_IDLE;
        cyc();
        current_state = S_TEST;
        cyc();
        tick_n(7);
        current_state = S_IDLE;
        repeat (2) cyc();
        check("abort_hold_reaction", 32'(reaction_ms), 32'h3FFF);
        check("abort_hold_ok", 32'(result_ok), 32'd0);

        // slower and equal runs do not beat the best, faster one does
        run_ok(300);
        run_ok(250);
        run_ok(200);

        // PREP straight to RESULT_FAIL
        current_state = S_PREP;
        cyc();
        tick_n(10);
        push_fail();
        current_state = S_FAIL;
        cyc();
        current_state = S_IDLE;
        cyc();

        // tick coincident with TEST entry is swallowed by the clear
        current_state = S_PREP;
        cyc();
        current_state    = S_TEST;
        rising_edge_1khz = 1'b1;
        repeat (6) cyc();
        rising_edge_1khz = 1'b0;
        push_ok(14'd5);
        current_state = S_OK;
        cyc();
        current_state = S_IDLE;
        cyc();

        // unused state codes behave as IDLE
        current_state = S_PREP;
        cyc();
        current_state = S_TEST;
        cyc();
        tick_n(1005);
        cyc();
        check("code6_pre", 32'(test_timeout), 32'd1);
        current_state = 3'd6;
        #1;
        check("code6_gate", 32'(test_timeout), 32'd0);
        cyc();
        current_state = S_OK;
        cyc();
        current_state = 3'd5;
        repeat (2) cyc();
        check("code6_no_latch", 32'(reaction_ms), 32'd5);

        // reaction counter saturates
        current_state = S_PREP;
        cyc();
        current_state = S_TEST;
        cyc();
        tick_n(16390);
        check("sat_timeout", 32'(test_timeout), 32'd1);
        push_ok(14'h3FFF);
        current_state = S_OK;
        cyc();
        current_state = S_IDLE;
        cyc();
        check("sat_ok", 32'(result_ok), 32'd1);

        // reset mid-TEST at rt_cnt = 100
        current_state = S_PREP;
        cyc();
        current_state = S_TEST;
        cyc();
        tick_n(100);
        reset_n = 1'b0;
        exp_best = 14'h3FFF;
        #1;
        check("mid_rst_reaction_ms", 32'(reaction_ms), 32'd0);
        check("mid_rst_result_ok", 32'(result_ok), 32'd0);
        check("mid_rst_result_valid", 32'(result_valid), 32'd0);
        check("mid_rst_best_ms", 32'(best_ms), 32'h3FFF);
        check("mid_rst_new_best", 32'(new_best), 32'd0);
        check("mid_rst_test_timeout", 32'(test_timeout), 32'd0);
        current_state = S_IDLE;
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (2) cyc();

        // LFSR restarts from its seed, best score restarts
        prep_timing("prep_after_rst");
        run_ok(250);

        repeat (3) cyc();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_timing_ctrl.md
REACTION_TIMING_CTRL -- requirements
Module: reaction_timing_ctrl

Interface
REQ-001 Parameter PREP_MIN_MS, default 1000, minimum PREP duration in 1 ms ticks.
REQ-002 Parameter PREP_MASK, default 2047, mask applied to the LFSR for the random PREP extension (0..PREP_MASK ms).
REQ-003 Parameter TEST_LIMIT_MS, default 1000, TEST duration before test_timeout.
REQ-004 Ports: clock  in  1  system clock; the only clock.
REQ-005 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: rising_edge_1khz  in  1  single-cycle 1 ms tick, synchronous to clock.
REQ-007 Ports: current_state  in  3  FSM state: IDLE=0, PREP=1, TEST=2, RESULT_OK=3, RESULT_FAIL=4; any other code is treated as IDLE.
REQ-008 Ports: prep_timeout  out  1  registered, high while in PREP once the random delay has elapsed.
REQ-009 Ports: test_timeout  out  1  registered, high while in TEST once TEST_LIMIT_MS has elapsed.
REQ-010 Ports: reaction_ms  out  14  last latched reaction time in ms.
REQ-011 Ports: result_valid  out  1  one-cycle pulse when a result is latched.
REQ-012 Ports: result_ok  out  1  qualifier of the latched result: 1 = OK, 0 = fail.
REQ-013 Ports: best_ms  out  14  best (lowest) OK reaction time since reset.
REQ-014 Ports: new_best  out  1  one-cycle pulse coincident with result_valid when best_ms improves.

Function
REQ-015 Entry detection: prev_state register; an entry is any cycle where current_state != prev_state.
REQ-016 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advances every clock cycle; never all-zero.
REQ-017 On PREP entry: prep_target <= PREP_MIN_MS + (lfsr & PREP_MASK); prep_cnt <= 0; width 14 bits, no overflow for defaults.
REQ-018 In PREP: prep_cnt +1 per rising_edge_1khz; prep_timeout asserts the cycle after prep_cnt >= prep_target and holds until PREP exits.
REQ-019 On TEST entry: rt_cnt <= 0; in TEST rt_cnt +1 per tick, saturating at 14'h3FFF.
REQ-020 test_timeout asserts the cycle after rt_cnt >= TEST_LIMIT_MS and holds until TEST exits.
REQ-021 Entry clear has priority over a same-cycle tick; count starts at 0 (first tick after entry gives 1).
REQ-022 prep_timeout and test_timeout SHALL be 0 in every state other than their own, including the cycle of exit.
REQ-023 TEST->RESULT_OK: reaction_ms <= rt_cnt, result_ok <= 1, result_valid pulses 1 cycle.
REQ-024 TEST->RESULT_FAIL or PREP->RESULT_FAIL: reaction_ms <= 14'h3FFF, result_ok <= 0, result_valid pulses 1 cycle.
REQ-025 Any other transition (e.g. PREP->IDLE or TEST->IDLE) latches nothing; reaction_ms, result_ok hold.
REQ-026 reaction_ms, result_ok hold through RESULT and IDLE until the next latched result.

Reset
REQ-027 reset_n low asynchronously forces: lfsr=16'hACE1, prev_state=IDLE, counters=0, prep_target=PREP_MIN_MS, prep_timeout=0, test_timeout=0, reaction_ms=0, result_ok=0, result_valid=0, best_ms=14'h3FFF, new_best=0.
REQ-028 Reset asserted mid-PREP or mid-TEST SHALL abort with no result_valid pulse; operation resumes on the first clock after release.

Configuration
REQ-029 Macro BEST_SCORE_EN defined: on an OK result with rt_cnt < best_ms, best_ms <= rt_cnt and new_best pulses with result_valid; equal time is not a new best.
REQ-030 BEST_SCORE_EN undefined: best-score logic is absent, best_ms is tied to 14'h3FFF and new_best to 0.

Verification
REQ-031 IDLE->PREP with lfsr & 2047 = N at entry -> prep_timeout rises exactly 1 cycle after the (1000+N)th tick.
REQ-032 PREP->TEST, 250 ticks, then TEST->RESULT_OK -> reaction_ms=250, result_ok=1, one result_valid pulse; with BEST_SCORE_EN best_ms=250, new_best pulses.
REQ-033 TEST held 1000 ticks -> test_timeout high 1 cycle after 1000th tick; TEST->RESULT_FAIL -> reaction_ms=14'h3FFF, result_ok=0, best_ms unchanged.
REQ-034 Second OK run of 300 after 250 -> reaction_ms=300, best_ms stays 250, no new_best; run of 250 -> no new_best.
REQ-035 reset_n pulsed low mid-TEST at rt_cnt=100 -> all outputs at reset values immediately, no result_valid.
REQ-036 Tick coincident with TEST entry, then 5 ticks, then RESULT_OK -> reaction_ms=5.
